// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder.
// Contents: frame state encoding, default fill byte and a saturating
// byte-counter increment.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } spi_state_e;

    localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   d_i         : asynchronous input
//   level_o     : synchronized level
//   rise_o      : 1-cycle pulse on a 0->1 change of level_o
//   fall_o      : 1-cycle pulse on a 1->0 change of level_o
module spi_slave_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
        prev_d  = chain_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign level_o = chain_q[STAGES-1];
    assign rise_o  = chain_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI mode-0 responder, MSB first, oversampled in the clk domain.
// Ports:
//   clk, _reset            : system clock, asynchronous active-low reset
//   _cs_i, sclk_i, mosi_i  : raw SPI inputs from the master
//   miso_o, miso_oe        : slave output data and its enable (high while ACTIVE)
//   rx_data, rx_valid      : last complete received byte and its 1-cycle strobe
//   tx_data, tx_valid      : next byte to send, offered by the user
//   tx_ack, tx_underrun    : tx_data consumed / FILL_BYTE loaded instead
//   frame_start, frame_end : _cs assertion / deassertion pulses
//   frame_err              : frame ended on a partial byte
//   byte_cnt               : complete bytes in the current frame (saturating)
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE   = DEFAULT_FILL_BYTE,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       _cs_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic       tx_underrun,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_err,
    output logic [7:0] byte_cnt
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_s;

    // _cs synchronizer resets to "asserted" so a frame already running at
    // reset release cannot be mistaken for a fresh _cs falling edge.
    spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk(clk), .rst_n(_reset), .d_i(_cs_i),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(_reset), .d_i(sclk_i),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    // mosi only needs the same delay as sclk so it lines up with sclk_rise.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    spi_state_e state_q, state_d;
    logic       miso_q, miso_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ack_q, tx_ack_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end_q, frame_end_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] load_byte;

    assign load_byte = tx_valid ? tx_data : FILL_BYTE;

    always_comb begin
        state_d       = state_q;
        miso_d        = miso_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        rx_valid_d    = 1'b0;
        tx_ack_d      = 1'b0;
        tx_underrun_d = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                miso_d = 1'b1;
                if (cs_lvl) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                miso_d = 1'b1;
                if (cs_fall) begin
                    frame_start_d = 1'b1;
                    byte_cnt_d    = 8'd0;
                    bit_cnt_d     = 3'd0;
                    tx_shift_d    = load_byte;
                    tx_ack_d      = tx_valid;
                    tx_underrun_d = ~tx_valid;
                    miso_d        = load_byte[7];
                    state_d       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
                        byte_cnt_d = sat_inc8(byte_cnt_q);
                    end
                end
                // A falling sclk coinciding with _cs release is the tail of
                // the last byte, so it must not pull in another tx byte.
                if (sclk_fall && !cs_rise) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_shift_d    = load_byte;
                        tx_ack_d      = tx_valid;
                        tx_underrun_d = ~tx_valid;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    miso_d = tx_shift_d[7];
                end
                // bit_cnt_d already includes a same-cycle sclk rise, so a bit
                // completing the byte here is not reported as partial.
                if (cs_rise) begin
                    frame_end_d = 1'b1;
                    frame_err_d = (bit_cnt_d != 3'd0);
                    bit_cnt_d   = 3'd0;
                    miso_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q       <= ST_WAIT_IDLE;
            mosi_sync_q   <= '0;
            miso_q        <= 1'b1;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            rx_valid_q    <= 1'b0;
            tx_ack_q      <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mosi_sync_q   <= mosi_sync_d;
            miso_q        <= miso_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            rx_valid_q    <= rx_valid_d;
            tx_ack_q      <= tx_ack_d;
            tx_underrun_q <= tx_underrun_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign miso_o      = miso_q;
    assign miso_oe     = (state_q == ST_ACTIVE);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ack      = tx_ack_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_err   = frame_err_q;
    assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       _reset;
    logic       _cs_i;
    logic       sclk_i;
    logic       mosi_i;
    logic       miso_o;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ack;
    logic       tx_underrun;
    logic       frame_start;
    logic       frame_end;
    logic       frame_err;
    logic [7:0] byte_cnt;

    spi_slave #(.FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk(clk), ._reset(_reset), ._cs_i(_cs_i), .sclk_i(sclk_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .tx_underrun(tx_underrun),
        .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: collects DUT events, sampled on the inactive clock edge.
    logic [7:0] rx_got[$];
    int n_rx = 0, n_ack = 0, n_und = 0, n_fs = 0, n_fe = 0, n_ferr = 0, n_err_end = 0, n_oe = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_got.push_back(rx_data);
            n_rx++;
        end
        if (tx_ack) n_ack++;
        if (tx_underrun) n_und++;
        if (frame_start) n_fs++;
        if (frame_end) n_fe++;
        if (frame_err) n_ferr++;
        if (frame_err && frame_end) n_err_end++;
        if (miso_oe) n_oe++;
    end

    int checks = 0;
    int errors = 0;
    int rd_idx = 0;
    logic [7:0] exp_rx[$];
    int s_rx, s_ack, s_und, s_fs, s_fe, s_ferr, s_err_end, s_oe;
    logic [7:0] mi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_rx = n_rx; s_ack = n_ack; s_und = n_und; s_fs = n_fs;
        s_fe = n_fe; s_ferr = n_ferr; s_err_end = n_err_end; s_oe = n_oe;
    endtask

    // Master side of a transfer: nbits MSB-first bits of mo; miso sampled at
    // each sclk rise. With end_frame the final sclk fall and _cs release share
    // the same instant. next_tx is offered once the current byte is loaded.
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit end_frame,
                        input logic [7:0] next_tx, output logic [7:0] mo_in);
        mo_in = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            mosi_i = mo[7-k];
            wait_clk(HALF);
            if (k == 0) tx_data = next_tx;
            sclk_i = 1'b1;
            mo_in[7-k] = miso_o;
            wait_clk(HALF);
            sclk_i = 1'b0;
            if (end_frame && (k == nbits - 1)) _cs_i = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        chk({tag, " rx_count"}, 32'(rx_got.size() - rd_idx), 32'(exp_rx.size()));
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            if (rd_idx < rx_got.size()) begin
                chk({tag, " rx_data"}, 32'(rx_got[rd_idx]), 32'(e));
                rd_idx++;
            end
        end
        rd_idx = rx_got.size();
    endtask

    initial begin
        int bad;
        _reset = 1'b0; _cs_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        wait_clk(3);
        chk("reset miso_o", 32'(miso_o), 32'd1);
        chk("reset miso_oe", 32'(miso_oe), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
        chk("reset byte_cnt", 32'(byte_cnt), 32'd0);
        chk("reset pulses", 32'({rx_valid, tx_ack, tx_underrun, frame_start, frame_end, frame_err}), 32'd0);
        _reset = 1'b1;
        wait_clk(10);

        // Single byte
        snap();
        tx_data = 8'h3C; tx_valid = 1'b1;
        _cs_i = 1'b0;
        wait_clk(HALF);
        chk("single miso_oe", 32'(miso_oe), 32'd1);
        exp_rx.push_back(8'hA5);
        xfer(8'hA5, 8, 1'b1, 8'h3C, mi);
        wait_clk(8);
        chk("single miso", 32'(mi), 32'h3C);
        drain("single");
        chk("single tx_ack", 32'(n_ack - s_ack), 32'd1);
        chk("single frame_start", 32'(n_fs - s_fs), 32'd1);
        chk("single frame_end", 32'(n_fe - s_fe), 32'd1);
        chk("single frame_err", 32'(n_ferr - s_ferr), 32'd0);
        chk("single byte_cnt", 32'(byte_cnt), 32'd1);
        chk("single underrun", 32'(n_und - s_und), 32'd0);
        chk("idle miso_o", 32'(miso_o), 32'd1);
        wait_clk(2 * HALF);

        // Multi-byte with tx_data advancing on each ack
        snap();
        tx_data = 8'h01;
        _cs_i = 1'b0;
        wait_clk(HALF);
        exp_rx.push_back(8'h12);
        xfer(8'h12, 8, 1'b0, 8'h02, mi);
        chk("multi miso0", 32'(mi), 32'h01);
        exp_rx.push_back(8'h34);
        xfer(8'h34, 8, 1'b0, 8'h03, mi);
        chk("multi miso1", 32'(mi), 32'h02);
        exp_rx.push_back(8'h56);
        xfer(8'h56, 8, 1'b1, 8'h04, mi);
        chk("multi miso2", 32'(mi), 32'h03);
        wait_clk(8);
        drain("multi");
        chk("multi byte_cnt", 32'(byte_cnt), 32'd3);
        chk("multi tx_ack", 32'(n_ack - s_ack), 32'd3);
        chk("multi frame_err", 32'(n_ferr - s_ferr), 32'd0);
        wait_clk(2 * HALF);

        // Underrun
        snap();
        tx_valid = 1'b0;
        _cs_i = 1'b0;
        wait_clk(HALF);
        exp_rx.push_back(8'h9C);
        xfer(8'h9C, 8, 1'b0, 8'h55, mi);
        chk("under miso0", 32'(mi), 32'hFF);
        exp_rx.push_back(8'h63);
        xfer(8'h63, 8, 1'b1, 8'h55, mi);
        chk("under miso1", 32'(mi), 32'hFF);
        wait_clk(8);
        drain("under");
        chk("under tx_underrun", 32'(n_und - s_und), 32'd2);
        chk("under tx_ack", 32'(n_ack - s_ack), 32'd0);
        chk("under byte_cnt", 32'(byte_cnt), 32'd2);
        wait_clk(2 * HALF);

        // Partial byte
        snap();
        tx_valid = 1'b1; tx_data = 8'hAA;
        _cs_i = 1'b0;
        wait_clk(HALF);
        xfer(8'hF0, 5, 1'b1, 8'hAA, mi);
        wait_clk(8);
        drain("partial");
        chk("partial rx_valid", 32'(n_rx - s_rx), 32'd0);
        chk("partial frame_err", 32'(n_ferr - s_ferr), 32'd1);
        chk("partial err_with_end", 32'(n_err_end - s_err_end), 32'd1);
        chk("partial frame_end", 32'(n_fe - s_fe), 32'd1);
        chk("partial byte_cnt", 32'(byte_cnt), 32'd0);
        wait_clk(2 * HALF);

        // Reset mid-frame, released with _cs still low
        tx_data = 8'h11;
        _cs_i = 1'b0;
        wait_clk(HALF);
        xfer(8'hE7, 3, 1'b0, 8'h11, mi);
        _reset = 1'b0;
        wait_clk(2);
        _reset = 1'b1;
        wait_clk(1);
        snap();
        xfer(8'h3F, 5, 1'b0, 8'h11, mi);
        wait_clk(HALF);
        chk("rstmid miso_oe", 32'(n_oe - s_oe), 32'd0);
        chk("rstmid rx_valid", 32'(n_rx - s_rx), 32'd0);
        chk("rstmid frame_start", 32'(n_fs - s_fs), 32'd0);
        _cs_i = 1'b1;
        wait_clk(8);
        chk("rstmid frame_end", 32'(n_fe - s_fe), 32'd0);
        chk("rstmid miso_o", 32'(miso_o), 32'd1);
        wait_clk(2 * HALF);
        snap();
        tx_data = 8'h77;
        _cs_i = 1'b0;
        wait_clk(HALF);
        exp_rx.push_back(8'h5A);
        xfer(8'h5A, 8, 1'b1, 8'h77, mi);
        wait_clk(8);
        chk("after_rst miso", 32'(mi), 32'h77);
        drain("after_rst");
        chk("after_rst byte_cnt", 32'(byte_cnt), 32'd1);
        chk("after_rst frame_start", 32'(n_fs - s_fs), 32'd1);
        wait_clk(2 * HALF);

        // 256-byte frame: byte_cnt saturation
        snap();
        bad = 0;
        tx_data = 8'hC3;
        _cs_i = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 256; i++) begin
            exp_rx.push_back(i[7:0]);
            xfer(i[7:0], 8, (i == 255), 8'hC3, mi);
            if (mi !== 8'hC3) bad++;
        end
        wait_clk(8);
        chk("sat miso bytes_bad", 32'(bad), 32'd0);
        drain("sat");
        chk("sat rx_valid", 32'(n_rx - s_rx), 32'd256);
        chk("sat byte_cnt", 32'(byte_cnt), 32'd255);
        chk("sat tx_ack", 32'(n_ack - s_ack), 32'd256);
        chk("sat frame_err", 32'(n_ferr - s_ferr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Byte-oriented SPI responder (mode 0, MSB first) for the far end of the minimig SPI master. It serves as the device model in benches and as a synthesizable target.
- Oversamples _cs/sclk/mosi in the clk domain and delivers received bytes with a valid pulse.
- Shifts out bytes supplied over a valid/ack handshake.
- Reports frame start/end, byte count, underrun and partial-byte errors.

Parameters:
- FILL_BYTE, 8'hFF, byte shifted out when no tx byte is available
- SYNC_STAGES, 2, synchronizer depth on _cs_i, sclk_i, mosi_i (minimum 2)

Ports:
- clk  in  1  system clock; sclk half-period must be at least SYNC_STAGES+2 clk cycles
- _reset  in  1  reset, asynchronous assert, active-low
- _cs_i  in  1  chip select, active-low
- sclk_i  in  1  SPI clock, idles low (mode 0)
- mosi_i  in  1  master out
- miso_o  out  1  slave out
- miso_oe  out  1  high while the frame is ACTIVE
- rx_data  out  8  last complete received byte
- rx_valid  out  1  1-cycle pulse when rx_data updates
- tx_data  in  8  next byte to send
- tx_valid  in  1  tx_data is valid
- tx_ack  out  1  1-cycle pulse when tx_data is consumed
- tx_underrun  out  1  1-cycle pulse when FILL_BYTE is loaded instead of tx_data
- frame_start  out  1  1-cycle pulse on _cs assertion
- frame_end  out  1  1-cycle pulse on _cs deassertion
- frame_err  out  1  1-cycle pulse when a frame ends with a partial byte
- byte_cnt  out  8  complete bytes in the current frame; saturates at 255; holds after frame end until the next frame_start

Behaviour:
- Reset (_reset low, async):
  - miso_o=1, miso_oe=0, rx_data=0, byte_cnt=0.
  - All pulses 0, bit_cnt=0.
  - State = WAIT_IDLE.
- Synchronization: each input passes through SYNC_STAGES flops. Edges are detected on the synced signals (rise/fall = current vs previous synced value).
- States:
  - WAIT_IDLE: ignore all activity. Go to IDLE when synced _cs is high. This discards any frame in progress at reset release.
  - IDLE: miso_oe=0, miso_o=1. On synced _cs falling:
    - pulse frame_start; byte_cnt=0, bit_cnt=0;
    - load tx_shift from tx_data with tx_ack if tx_valid, else from FILL_BYTE with tx_underrun;
    - miso_o=shift[7]; go to ACTIVE.
  - ACTIVE, synced sclk rising: rx_shift={rx_shift[6:0],mosi}; bit_cnt++ (3-bit wrap). When bit_cnt was 7:
    - rx_data={rx_shift[6:0],mosi} with rx_valid the same cycle;
    - byte_cnt++ (saturating).
  - ACTIVE, synced sclk falling:
    - if bit_cnt==0 (byte boundary): reload tx_shift by the same tx_valid/FILL rule (tx_ack or tx_underrun);
    - else shift tx_shift left.
    - miso_o=new shift[7].
  - ACTIVE, synced _cs rising:
    - pulse frame_end; frame_err as well if bit_cnt!=0;
    - discard the partial byte; go to IDLE.
- Simultaneous events:
  - sclk rising and _cs rising in the same cycle: the bit is sampled (and rx_valid issued if it completes a byte) before frame end is processed.
  - sclk falling and _cs rising in the same cycle: no reload and no tx_ack.
- Latency:
  - rx_valid occurs SYNC_STAGES+1 clk after the raw 8th sclk rising edge.
  - miso_o changes SYNC_STAGES+1 clk after the raw sclk falling edge, or after the raw _cs falling edge for the first bit.
- A sclk edge while _cs is high is ignored.
- A frame of zero clocks gives frame_start then frame_end with no error; one byte is still consumed (tx_ack) at frame start.

Decomposition:
- Shared header spi_defs.vh: state encodings (WAIT_IDLE, IDLE, ACTIVE) and the default FILL_BYTE.
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect. Instantiated for _cs and sclk; mosi uses the synchronizer output only.

Test Plan:
- Single byte: master sends 0xA5 with tx_data=0x3C, tx_valid=1 -> rx_data=0xA5 with one rx_valid; miso bits sampled by the master = 0x3C; exactly one tx_ack; byte_cnt=1; frame_start and frame_end once each; frame_err=0.
- Multi-byte: 3-byte frame 0x12,0x34,0x56 with tx_valid high and tx_data changed to 0x01,0x02,0x03 on each ack -> three rx_valid pulses in order; master receives 0x01,0x02,0x03; byte_cnt=3.
- Underrun: tx_valid=0 for a 2-byte frame -> master receives 0xFF,0xFF; two tx_underrun pulses; no tx_ack.
- Partial byte: _cs deasserted after 5 sclk pulses -> no rx_valid; frame_err and frame_end in the same cycle; byte_cnt=0.
- Reset mid-frame: assert _reset after 3 bits, release with _cs still low, finish the byte -> no rx_valid and miso_oe=0 until _cs goes high; the next full frame is received correctly.
- Boundary: 256-byte frame -> byte_cnt saturates at 255; rx_valid fires 256 times.
